// File: rtl/digit_scan_display.sv
// digit_scan_display: multiplexed 4-digit common-anode 7-segment driver with
// frame-coherent snapshot, per-digit blink, colon and anti-ghost guard blanking.
module digit_scan_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 2,
    parameter int BLINK_DIV = 128,
    parameter int LZ_BLANK  = 1
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic [3:0] hTens,
    input  logic [3:0] hUnits,
    input  logic [3:0] mTens,
    input  logic [3:0] mUnits,
    input  logic [3:0] blink_en,
    input  logic       colon_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_DIV + 1);
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [FW-1:0] frame;
    logic          phase;
    logic [15:0]   snap;
    logic          tick, wrap, active, blank, frame_end;
    logic [3:0]    digit, an_n;
    logic [6:0]    seg_n;

    assign tick      = presc == PW'(SCAN_DIV - 1);
    assign wrap      = tick && idx == 2'd3;
    assign frame_end = frame == FW'(BLINK_DIV - 1);
    assign digit     = snap[{idx, 2'b00} +: 4];

    generate
        if (GUARD == 0) begin : g_noguard
            assign active = 1'b1;
        end else begin : g_guard
            assign active = presc >= PW'(GUARD);
        end
    endgenerate

    // Blink and leading-zero suppression both just keep the anode off
    assign blank = (blink_en[idx] && phase) ||
                   (LZ_BLANK != 0 && idx == 2'd3 && snap[15:12] == 4'd0);
    assign an_n  = (active && !blank) ? ~(4'b0001 << idx) : 4'b1111;

    always_comb begin
        seg_n = 7'h3F;
        case (digit)
            4'd0: seg_n = 7'h40;
            4'd1: seg_n = 7'h79;
            4'd2: seg_n = 7'h24;
            4'd3: seg_n = 7'h30;
            4'd4: seg_n = 7'h19;
            4'd5: seg_n = 7'h12;
            4'd6: seg_n = 7'h02;
            4'd7: seg_n = 7'h78;
            4'd8: seg_n = 7'h00;
            4'd9: seg_n = 7'h10;
            default: seg_n = 7'h3F;
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
            frame <= '0;
            phase <= 1'b0;
            snap  <= '0;
            an    <= 4'b1111;
            seg   <= 7'h7F;
            dp    <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= idx + 1'b1;
            // One coherent time per frame: capture all digits together at frame start
            if (wrap) begin
                snap  <= {hTens, hUnits, mTens, mUnits};
                frame <= frame_end ? '0 : frame + 1'b1;
                if (frame_end)
                    phase <= ~phase;
            end
            an  <= an_n;
            seg <= seg_n;
            dp  <= !(idx == 2'd2 && colon_en && !phase && active);
        end
    end
endmodule

// File: tb/tb_digit_scan_display.sv
// tb_digit_scan_display: directed checks of scan order, guard, snapshot, blink,
// colon, async reset, leading-zero blank, dash decode and zero-guard operation.
module tb_digit_scan_display;
    logic       clkin = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] hTens = 4'd1, hUnits = 4'd2, mTens = 4'd3, mUnits = 4'd4;
    logic [3:0] blink_en = 4'b0000;
    logic       colon_en = 1'b0;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;
    int tests = 0;
    int fails = 0;
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    always #5 clkin = ~clkin;

    digit_scan_display #(.SCAN_DIV(4), .GUARD(1), .BLINK_DIV(2), .LZ_BLANK(1)) dut_a (
        .clkin(clkin), .reset(reset), .hTens(hTens), .hUnits(hUnits), .mTens(mTens),
        .mUnits(mUnits), .blink_en(blink_en), .colon_en(colon_en),
        .seg(seg_a), .dp(dp_a), .an(an_a));

    digit_scan_display #(.SCAN_DIV(4), .GUARD(0), .BLINK_DIV(2), .LZ_BLANK(0)) dut_b (
        .clkin(clkin), .reset(reset), .hTens(hTens), .hUnits(hUnits), .mTens(mTens),
        .mUnits(mUnits), .blink_en(blink_en), .colon_en(colon_en),
        .seg(seg_b), .dp(dp_b), .an(an_b));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkin);
            @(negedge clkin);
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({an_a, seg_a, dp_a} !== {4'b1111, 7'h7F, 1'b1}) begin
            fails++;
            $display("FAIL reset_async an=%b seg=%h dp=%b want 1111/7f/1", an_a, seg_a, dp_a);
        end
        @(posedge clkin);
        #1;
        tests++;
        if ({an_a, seg_a, dp_a} !== {4'b1111, 7'h7F, 1'b1}) begin
            fails++;
            $display("FAIL reset_held an=%b seg=%h dp=%b want 1111/7f/1", an_a, seg_a, dp_a);
        end
        @(negedge clkin);
        reset = 1'b0;
    endtask

    task automatic test_scan;
        step(16);
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 4; c++) begin
                step(1);
                tests++;
                if (an_a !== (c == 0 ? 4'b1111 : an_tab[s])) begin
                    fails++;
                    $display("FAIL scan_an slot%0d cyc%0d an=%b want %b", s, c, an_a,
                             c == 0 ? 4'b1111 : an_tab[s]);
                end
                if (c > 0) begin
                    tests++;
                    if (seg_a !== seg_tab[s] || dp_a !== 1'b1) begin
                        fails++;
                        $display("FAIL scan_seg slot%0d seg=%h dp=%b want %h/1", s, seg_a, dp_a, seg_tab[s]);
                    end
                end
            end
    endtask

    task automatic test_snapshot;
        step(2);
        mUnits = 4'd5;
        hUnits = 4'd7;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (seg_a !== 7'h19 || an_a !== 4'b1110) begin
                fails++;
                $display("FAIL snap_hold_slot0 seg=%h an=%b want 19/1110", seg_a, an_a);
            end
            if (c < 2) step(1);
        end
        step(7);
        tests++;
        if (seg_a !== 7'h24 || an_a !== 4'b1011) begin
            fails++;
            $display("FAIL snap_hold_slot2 seg=%h an=%b want 24/1011", seg_a, an_a);
        end
        step(7);
        tests++;
        if (seg_a !== 7'h12 || an_a !== 4'b1110) begin
            fails++;
            $display("FAIL snap_new_slot0 seg=%h an=%b want 12/1110", seg_a, an_a);
        end
        step(8);
        tests++;
        if (seg_a !== 7'h78 || an_a !== 4'b1011) begin
            fails++;
            $display("FAIL snap_new_slot2 seg=%h an=%b want 78/1011", seg_a, an_a);
        end
        step(6);
    endtask

    task automatic test_blink;
        logic [3:0] ea;
        logic       ed;
        blink_en = 4'b1100;
        colon_en = 1'b1;
        for (int f = 0; f < 4; f++)
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < 4; c++) begin
                    step(1);
                    ea = (c == 0 || (s >= 2 && f >= 2)) ? 4'b1111 : an_tab[s];
                    ed = !(s == 2 && c > 0 && f < 2);
                    tests++;
                    if (an_a !== ea || dp_a !== ed) begin
                        fails++;
                        $display("FAIL blink f%0d slot%0d cyc%0d an=%b dp=%b want %b/%b",
                                 f, s, c, an_a, dp_a, ea, ed);
                    end
                end
        blink_en = 4'b0000;
        colon_en = 1'b0;
    endtask

    task automatic test_mid_reset;
        step(10);
        tests++;
        if (an_a !== 4'b1011) begin
            fails++;
            $display("FAIL pre_reset_slot2 an=%b want 1011", an_a);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({an_a, seg_a, dp_a} !== {4'b1111, 7'h7F, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset an=%b seg=%h dp=%b want 1111/7f/1", an_a, seg_a, dp_a);
        end
        hTens = 4'd0;
        @(negedge clkin);
        reset = 1'b0;
        step(1);
        tests++;
        if (an_a !== 4'b1111) begin
            fails++;
            $display("FAIL post_reset_guard an=%b want 1111", an_a);
        end
        step(1);
        tests++;
        if (an_a !== 4'b1110) begin
            fails++;
            $display("FAIL post_reset_slot0 an=%b want 1110", an_a);
        end
    endtask

    task automatic test_lz_guard0;
        for (int k = 3; k <= 48; k++) begin
            step(1);
            tests++;
            if (an_a[3] !== 1'b1) begin
                fails++;
                $display("FAIL lz_blank k%0d an=%b want an[3]=1", k, an_a);
            end
            tests++;
            if ($isunknown(an_b) || $countones(~an_b) != 1) begin
                fails++;
                $display("FAIL guard0_onehot k%0d an=%b want one low bit", k, an_b);
            end
            if (k == 46) begin
                tests++;
                if (an_b !== 4'b0111 || seg_b !== 7'h40) begin
                    fails++;
                    $display("FAIL nolz_zero an=%b seg=%h want 0111/40", an_b, seg_b);
                end
            end
        end
    endtask

    task automatic test_dash;
        hTens = 4'd15;
        step(30);
        tests++;
        if (an_a !== 4'b0111 || seg_a !== 7'h3F) begin
            fails++;
            $display("FAIL dash_a an=%b seg=%h want 0111/3f", an_a, seg_a);
        end
        tests++;
        if (an_b !== 4'b0111 || seg_b !== 7'h3F) begin
            fails++;
            $display("FAIL dash_b an=%b seg=%h want 0111/3f", an_b, seg_b);
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_snapshot;
        test_blink;
        test_mid_reset;
        test_lz_guard0;
        test_dash;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
